// File: rtl/result_collector.sv
// Collects four convolution output elements from a PE/systolic array, one
// strobe per element in any order, then drains them in element order
// (r00, r01, r10, r11) over a valid/ready port. Protocol misuse raises a
// sticky err flag without disturbing already stored values.
module result_collector #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  input  logic              c00,
  input  logic              c01,
  input  logic              c10,
  input  logic              c11,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_addr,
  output logic [DATA_W-1:0] r00,
  output logic [DATA_W-1:0] r01,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        addr_q, addr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] res_q [4];
  logic [DATA_W-1:0] res_d [4];

  logic [3:0] strobe;
  logic       one_hot;
  logic [1:0] idx;

  assign strobe  = {c11, c10, c01, c00};
  // Exactly one strobe high: non-zero and a power of two.
  assign one_hot = (strobe != 4'b0000) && ((strobe & (strobe - 4'd1)) == 4'b0000);

  // Encode the single active strobe into an element index.
  always_comb begin
    idx = 2'd0;
    unique case (strobe)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Next-state: capture, drain handshake, error flagging; clear wins over all.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    err_d   = err_q;
    for (int i = 0; i < 4; i++) res_d[i] = res_q[i];

    if (clear) begin
      state_d = StIdle;
      mask_d  = 4'b0000;
      addr_d  = 2'd0;
      err_d   = 1'b0;
      for (int i = 0; i < 4; i++) res_d[i] = '0;
    end else begin
      unique case (state_q)
        StIdle, StCollect: begin
          if (strobe != 4'b0000) begin
            if (!one_hot) begin
              err_d = 1'b1;
            end else if ((mask_q & strobe) != 4'b0000) begin
              // Duplicate element: keep the first value.
              err_d = 1'b1;
            end else begin
              mask_d     = mask_q | strobe;
              res_d[idx] = din;
              if ((mask_q | strobe) == 4'b1111) begin
                state_d = StDrain;
                addr_d  = 2'd0;
              end else begin
                state_d = StCollect;
              end
            end
          end
        end
        StDrain: begin
          if (strobe != 4'b0000) err_d = 1'b1;
          if (out_ready) begin
            if (addr_q == 2'd3) begin
              state_d = StDone;
              addr_d  = 2'd0;
            end else begin
              addr_d = addr_q + 2'd1;
            end
          end
        end
        StDone: begin
          if (strobe != 4'b0000) err_d = 1'b1;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= 4'b0000;
      addr_q  <= 2'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
    end
  end

  // Outputs decode directly from registered state, so rst drops them at once.
  always_comb begin
    out_valid = (state_q == StDrain);
    done      = (state_q == StDone);
    out_addr  = addr_q;
    out_data  = res_q[addr_q];
    err       = err_q;
    r00       = res_q[0];
    r01       = res_q[1];
    r10       = res_q[2];
    r11       = res_q[3];
  end

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed vectors, a behavioural model that
// tracks stored elements and a drained-word count, a per-cycle comparator,
// and literal spot checks.
module tb_result_collector;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              c00 = 1'b0, c01 = 1'b0, c10 = 1'b0, c11 = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid, done, err;
  logic [DATA_W-1:0] out_data, r00, r01, r10, r11;
  logic [1:0]        out_addr;

  int checks = 0;
  int errors = 0;

  result_collector #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .din(din),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .r00(r00), .r01(r01), .r10(r10), .r11(r11),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Model: which elements are held, their values, how many words drained.
  logic [DATA_W-1:0] m_mem [4] = '{default: '0};
  bit                m_have [4] = '{default: 1'b0};
  int                m_drained = 0;
  bit                m_err = 1'b0;

  function automatic bit m_all();
    return m_have[0] && m_have[1] && m_have[2] && m_have[3];
  endfunction

  always @(posedge clk or posedge rst) begin
    int n;
    int k;
    if (rst || clear) begin
      for (int i = 0; i < 4; i++) begin m_mem[i] = '0; m_have[i] = 1'b0; end
      m_drained = 0;
      m_err = 1'b0;
    end else begin
      n = int'(c00) + int'(c01) + int'(c10) + int'(c11);
      k = c00 ? 0 : c01 ? 1 : c10 ? 2 : 3;
      if (m_all()) begin
        if (n > 0) m_err = 1'b1;
        if (m_drained < 4 && out_ready) m_drained++;
      end else if (n > 1) begin
        m_err = 1'b1;
      end else if (n == 1) begin
        if (m_have[k]) m_err = 1'b1;
        else begin m_mem[k] = din; m_have[k] = 1'b1; end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accepted drain words, recorded as {addr, data}.
  logic [9:0] words [$];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit ev;
    int ea;
    ev = m_all() && (m_drained < 4);
    ea = m_drained % 4;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_addr", 32'(out_addr), 32'(ea));
    check("out_data", 32'(out_data), 32'(m_mem[ea]));
    check("r00", 32'(r00), 32'(m_mem[0]));
    check("r01", 32'(r01), 32'(m_mem[1]));
    check("r10", 32'(r10), 32'(m_mem[2]));
    check("r11", 32'(r11), 32'(m_mem[3]));
    check("done", 32'(done), 32'(m_drained == 4));
    check("err", 32'(err), 32'(m_err));
    if (out_valid && out_ready) words.push_back({out_addr, out_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input int k, input logic [DATA_W-1:0] v);
    din = v;
    c00 = (k == 0); c01 = (k == 1); c10 = (k == 2); c11 = (k == 3);
    step();
    c00 = 1'b0; c01 = 1'b0; c10 = 1'b0; c11 = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic check_words(input string name, input logic [DATA_W-1:0] d0,
                             input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                             input logic [DATA_W-1:0] d3);
    logic [DATA_W-1:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    check({name, "_count"}, 32'(words.size()), 32'd4);
    for (int i = 0; i < 4 && i < words.size(); i++)
      check({name, "_word"}, 32'(words[i]), 32'({2'(i), d[i]}));
    words.delete();
  endtask

  initial begin
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    // Four consecutive captures, sink always ready.
    out_ready = 1'b1;
    cap(0, 8'd5); cap(1, 8'd6); cap(2, 8'd7); cap(3, 8'd8);
    check("t1_valid_after_c11", 32'(out_valid), 32'd1);
    check("t1_addr_after_c11", 32'(out_addr), 32'd0);
    repeat (4) step();
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check_words("t1", 8'd5, 8'd6, 8'd7, 8'd8);

    // Out-of-order captures with gaps, then a stalling sink.
    do_clear();
    out_ready = 1'b0;
    cap(3, 8'h11); repeat (3) step();
    cap(0, 8'h22); repeat (3) step();
    cap(2, 8'h33); repeat (3) step();
    cap(1, 8'h44);
    for (int i = 0; i < 7; i++) begin
      out_ready = (i % 2 == 0);
      step();
      if (i == 1) check("t2_held_addr", 32'(out_addr), 32'd1);
      if (i == 1) check("t2_held_data", 32'(out_data), 32'h44);
    end
    check("t2_done", 32'(done), 32'd1);
    check_words("t2", 8'h22, 8'h44, 8'h33, 8'h11);

    // Two strobes at once, then a legal capture.
    do_clear();
    din = 8'd9; c00 = 1'b1; c01 = 1'b1;
    step();
    c00 = 1'b0; c01 = 1'b0;
    check("t3_r00", 32'(r00), 32'd0);
    check("t3_r01", 32'(r01), 32'd0);
    check("t3_err", 32'(err), 32'd1);
    cap(0, 8'd3);
    check("t3_r00_late", 32'(r00), 32'd3);
    check("t3_err_sticky", 32'(err), 32'd1);

    // Duplicate capture, then a strobe after completion.
    do_clear();
    cap(2, 8'd4); cap(2, 8'd2);
    check("t4_r10", 32'(r10), 32'd4);
    check("t4_err", 32'(err), 32'd1);
    out_ready = 1'b1;
    cap(0, 8'd1); cap(1, 8'd2); cap(3, 8'd3);
    repeat (4) step();
    check("t4_done", 32'(done), 32'd1);
    cap(1, 8'd99);
    check("t4_r01_kept", 32'(r01), 32'd2);
    check("t4_done_kept", 32'(done), 32'd1);
    words.delete();

    // Clear beats a completing capture, and beats a drain acceptance.
    do_clear();
    out_ready = 1'b0;
    cap(0, 8'd10); cap(1, 8'd11); cap(2, 8'd12);
    clear = 1'b1; din = 8'h55; c11 = 1'b1;
    step();
    clear = 1'b0; c11 = 1'b0;
    check("t5_r11", 32'(r11), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    cap(0, 8'd10); cap(1, 8'd11); cap(2, 8'd12); cap(3, 8'd13);
    check("t5_drain", 32'(out_valid), 32'd1);
    out_ready = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_valid2", 32'(out_valid), 32'd0);
    check("t5_addr2", 32'(out_addr), 32'd0);
    check("t5_r00", 32'(r00), 32'd0);
    words.delete();

    // Asynchronous reset mid-drain, then a full sequence.
    cap(0, 8'd21); cap(1, 8'd22); cap(2, 8'd23); cap(3, 8'd24);
    step(); step();
    check("t6_addr", 32'(out_addr), 32'd2);
    #2 rst = 1'b1;
    #1 check("t6_async_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    words.delete();
    cap(0, 8'hA0); cap(1, 8'hA1); cap(2, 8'hA2); cap(3, 8'hA3);
    repeat (4) step();
    check("t6_done", 32'(done), 32'd1);
    check_words("t6", 8'hA0, 8'hA1, 8'hA2, 8'hA3);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001: Parameter DATA_W, default 8, width of the array result bus and of every stored result.
REQ-002: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: clear  input  1  synchronous restart strobe, issued when the controller starts a new convolution.
REQ-005: din  input  DATA_W  result value presented by the PE or systolic array.
REQ-006: c00, c01, c10, c11  input  1 each  capture strobes marking din as output element (row,col).
REQ-007: out_valid  output  1  the drain word is valid.
REQ-008: out_ready  input  1  the downstream sink (display or RAM write port) accepts the word.
REQ-009: out_data  output  DATA_W  the drain word.
REQ-010: out_addr  output  2  element index of out_data: 0=r00, 1=r01, 2=r10, 3=r11.
REQ-011: r00, r01, r10, r11  output  DATA_W each  stored result registers, readable at all times.
REQ-012: done  output  1  all four words have been drained; held until clear or rst.
REQ-013: err  output  1  sticky protocol-error flag.

Function
REQ-014: The state machine SHALL have the states IDLE, COLLECT, DRAIN and DONE, with a 4-bit captured mask.
REQ-015: A capture SHALL occur when exactly one strobe is high in IDLE or COLLECT; the matching register loads din on that edge and its mask bit sets.
REQ-016: The first capture in IDLE SHALL move the state to COLLECT.
REQ-017: The edge that completes the mask (4'b1111) SHALL move the state to DRAIN, with out_valid=1, out_addr=0 and out_data=r00 in the following cycle.
REQ-018: In DRAIN, each cycle with out_valid&&out_ready SHALL advance out_addr by 1, in the order r00, r01, r10, r11.
REQ-019: out_data and out_addr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020: Acceptance at out_addr=3 SHALL move the state to DONE: out_valid=0, done=1, out_addr wraps to 0.
REQ-021: More than one strobe high in the same cycle SHALL capture nothing and set err.
REQ-022: A strobe for an already-captured element SHALL be ignored (the stored value is kept) and SHALL set err.
REQ-023: Any strobe in DRAIN or DONE SHALL be ignored and SHALL set err.
REQ-024: clear in any state SHALL, on the next edge, return the state to IDLE and zero the mask, r00..r11, out_valid, out_addr, done and err.
REQ-025: clear SHALL take priority over a strobe or a handshake in the same cycle.
REQ-026: Stored values SHALL be truncated to DATA_W bits; no saturation or arithmetic is performed.
REQ-027: out_data SHALL be a combinational select of the stored registers by out_addr.

Reset
REQ-028: While rst is high, the state SHALL be IDLE and the mask, r00..r11, out_valid, out_addr, done and err SHALL all be 0.
REQ-029: Deassertion of rst SHALL need no clear before the first capture is accepted.
REQ-030: rst asserted mid-DRAIN SHALL drop out_valid immediately, asynchronously.

Verification
REQ-031: Strobe c00, c01, c10, c11 on four consecutive cycles with din=5,6,7,8, out_ready=1 -> out_valid rises the cycle after the c11 edge; words (0,5),(1,6),(2,7),(3,8) follow on consecutive cycles; done=1; err=0.
REQ-032: Strobe order c11, c00, c10, c01 with gaps of 3 idle cycles, then out_ready toggling 1,0,1,0 -> drain order is still r00..r11, data is held stable during each out_ready=0 cycle, done=1 after the 4th acceptance.
REQ-033: c00 and c01 high together with din=9 -> r00=r01=0, err=1, state IDLE; a later single c00 with din=3 -> r00=3, err stays 1.
REQ-034: c10 twice (din=4, then din=2) -> r10=4, err=1; a strobe in DONE -> registers unchanged, err=1.
REQ-035: clear in the same cycle as c11 and an out_ready acceptance in DRAIN -> next cycle IDLE, all outputs 0, no capture.
REQ-036: rst pulse during DRAIN at out_addr=2 -> out_valid=0 immediately; after release, a full 4-capture sequence drains correctly.
